mux4_rr_arbitre: RTL and testbench

- Round-robin arbiter and sequencer for the shared 4:1 multiplexer (inputs I0..I3, select S, output Y).
- Four requesters compete for the mux. The block grants one at a time, drives S with the winner's index, and bounds how long any owner may hold the mux.
- Sits directly in front of the mux. Its output sel connects to the mux S.

---
 rtl/mux4_rr_arbitre_if.sv | 35 +++
 rtl/mux4_rr_arbitre.sv | 142 ++++++++++++++
 tb/tb_mux4_rr_arbitre.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbitre_if.sv
// Handshake bundle between the four requesters and the mux arbiter.
// The requester side (master) drives req; the arbiter side (slave) drives
// the one-hot grant, the mux select and the status pulses.
// busy_dbg mirrors the arbiter FSM state (0 = IDLE, 1 = BUSY) for observation.
interface mux4_rr_arbitre_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       active;
    logic       switch_p;
    logic       busy_dbg;

    // Handshake: req[i] is a level held by requester i for as long as it wants
    // mux input Ii. The arbiter samples req only at rising clock edges. The
    // request is accepted on the first edge where grant[i] becomes 1. The
    // requester owns the mux until it lowers req[i], or until the arbiter
    // rotates it out. There is no combinational path from req to any output.
    modport master (
        output req,
        input  grant,
        input  sel,
        input  active,
        input  switch_p,
        input  busy_dbg
    );

    modport slave (
        input  req,
        output grant,
        output sel,
        output active,
        output switch_p,
        output busy_dbg
    );
endinterface

// File: rtl/mux4_rr_arbitre.sv
// Round-robin arbiter and sequencer for a shared 4:1 mux.
// It grants one of four requesters and drives the mux select with the
// winner's index. It also bounds how long one owner may hold the mux while
// others wait. Default build: round-robin search starting after the last owner.
// Optional macro MUX_ARB_FIXED_PRIO_EN switches to fixed priority (0 highest).
// With that macro, preemption at MAX_HOLD goes only to a strictly
// higher-priority requester.
module mux4_rr_arbitre #(
    parameter int MAX_HOLD = 8
) (
    input logic             clk,
    input logic             rst_n,
    mux4_rr_arbitre_if.slave bus
);
    // Hold counter width derived from MAX_HOLD (legal range 2..256).
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [3:0]       grant_q;
    logic [1:0]       sel_q;
    logic [1:0]       last_q;
    logic [CNT_W-1:0] hold_q;
    logic             switch_q;

    logic [3:0]       cand_pre;
    logic [1:0]       win_rel;
    logic [1:0]       win_pre;
    logic             owner_req;
    logic             hold_full;

    // Winner search over a candidate vector. The caller only uses the result
    // when cand is non-zero.
    function automatic logic [1:0] pick(input logic [3:0] cand, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
`ifdef MUX_ARB_FIXED_PRIO_EN
        // Fixed priority: the lowest index wins and the pointer is ignored.
        for (int k = 0; k < 4; k++) begin
            idx = 2'(k);
            if (!found && cand[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
`else
        // Round robin: search last+1, last+2, ... so the previous owner comes last.
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && cand[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
`endif
        return pick;
    endfunction

    // Next-owner candidates for release and for forced rotation.
    always_comb begin
        owner_req = |(bus.req & grant_q);
        hold_full = (hold_q == HOLD_LAST);
`ifdef MUX_ARB_FIXED_PRIO_EN
        // Only strictly higher-priority (lower index) requesters may preempt.
        cand_pre = bus.req & ((4'b0001 << sel_q) - 4'b0001);
`else
        // Any other requester may take over; the owner itself is excluded.
        cand_pre = bus.req & ~grant_q;
`endif
        win_rel = pick(bus.req, last_q);
        win_pre = pick(cand_pre, last_q);
    end

    // Arbiter FSM with registered grant, select and switch pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_q  <= 4'b0000;
            sel_q    <= 2'b00;
            last_q   <= 2'b11;
            hold_q   <= '0;
            switch_q <= 1'b0;
        end else begin
            switch_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_q  <= 4'b0001 << win_rel;
                        sel_q    <= win_rel;
                        last_q   <= win_rel;
                        hold_q   <= '0;
                        switch_q <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!owner_req) begin
                        if (|bus.req) begin
                            // Direct hand-over, no idle bubble between owners.
                            grant_q  <= 4'b0001 << win_rel;
                            sel_q    <= win_rel;
                            last_q   <= win_rel;
                            hold_q   <= '0;
                            switch_q <= 1'b1;
                        end else begin
                            // Nobody left; sel keeps pointing at the last owner.
                            grant_q <= 4'b0000;
                            hold_q  <= '0;
                            state   <= IDLE;
                        end
                    end else if (hold_full && (|cand_pre)) begin
                        grant_q  <= 4'b0001 << win_pre;
                        sel_q    <= win_pre;
                        last_q   <= win_pre;
                        hold_q   <= '0;
                        switch_q <= 1'b1;
                    end else if (!hold_full) begin
                        hold_q <= hold_q + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.sel      = sel_q;
    assign bus.active   = |grant_q;
    assign bus.switch_p = switch_q;
    assign bus.busy_dbg = (state == BUSY);

endmodule

// File: tb/tb_mux4_rr_arbitre.sv
// Testbench for mux4_rr_arbitre. It runs a table of vectors from reset, a few
// hand sequences (hold, async reset, rotation, preemption) and a randomized
// phase. All phases are also checked against an owner/pointer model.
module tb_mux4_rr_arbitre;
    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mux4_rr_arbitre_if bus ();

    mux4_rr_arbitre #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_own;   // -1 when nobody owns the mux
    int m_last;
    int m_hold;
    int m_sel;
    bit m_sw;

    function automatic int m_pick(logic [3:0] c, int last);
`ifdef MUX_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (c[i]) return i;
`else
        for (int k = 1; k <= 4; k++) if (c[(last + k) % 4]) return (last + k) % 4;
`endif
        return -1;
    endfunction

    task automatic m_take(int w);
        m_own  = w;
        m_last = w;
        m_sel  = w;
        m_hold = 0;
        m_sw   = 1'b1;
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_last = 3;
        m_hold = 0;
        m_sel  = 0;
        m_sw   = 1'b0;
    endtask

    task automatic model_step(logic [3:0] r);
        logic [3:0] cand;
        m_sw = 1'b0;
        if (m_own < 0) begin
            if (r != 4'b0) m_take(m_pick(r, m_last));
        end else if (!r[m_own]) begin
            if (r != 4'b0) m_take(m_pick(r, m_last));
            else m_own = -1;
        end else begin
`ifdef MUX_ARB_FIXED_PRIO_EN
            cand = r & 4'((1 << m_own) - 1);
`else
            cand = r & ~4'(1 << m_own);
`endif
            if (m_hold == MAX_HOLD - 1 && cand != 4'b0) m_take(m_pick(cand, m_last));
            else if (m_hold < MAX_HOLD - 1) m_hold++;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        logic [3:0] eg;
        eg = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
        chk("model_grant",  8'(bus.grant),    8'(eg));
        chk("model_sel",    8'(bus.sel),      8'(m_sel));
        chk("model_active", 8'(bus.active),   8'(m_own >= 0));
        chk("model_switch", 8'(bus.switch_p), 8'(m_sw));
        chk("model_busy",   8'(bus.busy_dbg), 8'(m_own >= 0));
    endtask

    // ---------------- driver tasks ----------------
    // Apply req for one clock edge, then sample 1 time unit after the edge.
    task automatic cycle(logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        model_step(r);
        #1;
        chk_model();
    endtask

    // Assert reset away from the edge, check the outputs drop at once, then release.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_grant",  8'(bus.grant),    8'h00);
        chk("rst_sel",    8'(bus.sel),      8'h00);
        chk("rst_active", 8'(bus.active),   8'h00);
        chk("rst_switch", 8'(bus.switch_p), 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       sw;
    } vec_t;

    vec_t tbl[11];
    logic [3:0] r;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        bus.req     = 4'b0000;
        model_reset();
        #2;
        do_reset();

`ifndef MUX_ARB_FIXED_PRIO_EN
        // Vector table, applied from reset (pointer at 3, idle, sel 00).
        tbl[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b0};
        tbl[2]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[3]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[4]  = '{4'b0000, 4'b0000, 2'd3, 1'b0};
        tbl[5]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        tbl[6]  = '{4'b1110, 4'b0010, 2'd1, 1'b1};
        tbl[7]  = '{4'b1101, 4'b0100, 2'd2, 1'b1};
        tbl[8]  = '{4'b1011, 4'b1000, 2'd3, 1'b1};
        tbl[9]  = '{4'b0111, 4'b0001, 2'd0, 1'b1};
        tbl[10] = '{4'b0001, 4'b0001, 2'd0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].req);
            chk($sformatf("tbl%0d_grant", i),  8'(bus.grant),    8'(tbl[i].grant));
            chk($sformatf("tbl%0d_sel", i),    8'(bus.sel),      8'(tbl[i].sel));
            chk($sformatf("tbl%0d_active", i), 8'(bus.active),   8'(|tbl[i].grant));
            chk($sformatf("tbl%0d_switch", i), 8'(bus.switch_p), 8'(tbl[i].sw));
        end

        // Single requester from idle: held well past MAX_HOLD, one switch pulse.
        cycle(4'b0000);
        for (int c = 0; c < 20; c++) begin
            cycle(4'b0100);
            chk("single_grant",  8'(bus.grant),    8'h04);
            chk("single_sel",    8'(bus.sel),      8'h02);
            chk("single_switch", 8'(bus.switch_p), 8'(c == 0));
        end

        // Reset mid-grant drops the grant immediately, search restarts at 0.
        #2;
        do_reset();

        // Rotation: each owner drops its request after 3 cycles of grant.
        cycle(4'b1111);
        chk("rot_first_grant", 8'(bus.grant), 8'h01);
        chk("rot_first_sel",   8'(bus.sel),   8'h00);
        for (int k = 0; k < 4; k++) begin
            cycle(4'b1111);
            chk("rot_hold_grant", 8'(bus.grant), 8'(1 << k));
            cycle(4'b1111);
            chk("rot_hold_grant", 8'(bus.grant), 8'(1 << k));
            r = 4'b1111 & ~4'(1 << k);
            cycle(r);
            chk("rot_next_grant",  8'(bus.grant),    8'(1 << ((k + 1) % 4)));
            chk("rot_next_switch", 8'(bus.switch_p), 8'h01);
            chk("rot_next_active", 8'(bus.active),   8'h01);
        end

        // Preemption: two constant requesters alternate every MAX_HOLD cycles.
        do_reset();
        for (int c = 0; c < 3 * MAX_HOLD; c++) begin
            cycle(4'b0011);
            chk("preempt_grant", 8'(bus.grant),
                8'((c / MAX_HOLD) % 2 == 0 ? 4'b0001 : 4'b0010));
            chk("preempt_switch", 8'(bus.switch_p), 8'(c % MAX_HOLD == 0));
        end
`else
        // Fixed priority: 0 holds against 3 indefinitely.
        for (int c = 0; c < 30; c++) begin
            cycle(4'b1001);
            chk("fixed_hold_grant", 8'(bus.grant), 8'h01);
        end
        // Owner 3 at full hold is preempted by a newly raised requester 0.
        do_reset();
        for (int c = 0; c < MAX_HOLD; c++) cycle(4'b1000);
        cycle(4'b1001);
        chk("fixed_preempt_grant",  8'(bus.grant),    8'h01);
        chk("fixed_preempt_switch", 8'(bus.switch_p), 8'h01);
`endif

        // Randomized phase against the model, with one random mid-run reset.
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            if (m_own >= 0 && $urandom_range(0, 15) == 0) r[m_own] = 1'b0;
            cycle(r);
            if (c == 300) begin
                #2;
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
